// File: rtl/pc_seq8_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the pc_seq8 program-counter sequencer:
//   PC_W        program-counter width (8)
//   pc_t        program-counter / address type
//   cmd_e       decoded command, produced by the priority decoder
//   decode_cmd  fixed-priority decode ret > call > jmp > increment
//   pc_inc      modulo-256 increment (0xFF wraps to 0x00, no flag)
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int PC_W = 8;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [2:0] {
        CMD_INC,
        CMD_JMP,
        CMD_CALL,
        CMD_RET,
        CMD_HOLD
    } cmd_e;

    // Only the highest-priority request acts; en=0 masks every request.
    function automatic cmd_e decode_cmd(input logic en,
                                        input logic ret,
                                        input logic call,
                                        input logic jmp);
        cmd_e c;
        if (!en) begin
            c = CMD_HOLD;
        end else if (ret) begin
            c = CMD_RET;
        end else if (call) begin
            c = CMD_CALL;
        end else if (jmp) begin
            c = CMD_JMP;
        end else begin
            c = CMD_INC;
        end
        return c;
    endfunction

    function automatic pc_t pc_inc(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/pc_seq8_if.sv
// -----------------------------------------------------------------------------
// pc_seq8_if
// Request/status bundle of the pc_seq8 sequencer.
//   master : drives en, jmp, call, ret, target; observes the status outputs
//   slave  : the sequencer itself
// Signals:
//   en        advance enable
//   jmp       absolute jump request
//   call      call request (push return address, then jump)
//   ret       return request (pop stack into pc)
//   target    jump/call destination
//   pc        current program counter
//   pc_next   combinational value pc takes at the next enabled edge
//   sp        stack occupancy 0..DEPTH
//   stk_full  sp == DEPTH
//   stk_empty sp == 0
//   err       sticky overflow/underflow flag
// -----------------------------------------------------------------------------
interface pc_seq8_if #(
    parameter int DEPTH = 4
);
    import pc_seq_pkg::*;

    localparam int SP_W = $clog2(DEPTH + 1);

    logic            en;
    logic            jmp;
    logic            call;
    logic            ret;
    pc_t             target;
    pc_t             pc;
    pc_t             pc_next;
    logic [SP_W-1:0] sp;
    logic            stk_full;
    logic            stk_empty;
    logic            err;

    modport master (
        output en, jmp, call, ret, target,
        input  pc, pc_next, sp, stk_full, stk_empty, err
    );

    modport slave (
        input  en, jmp, call, ret, target,
        output pc, pc_next, sp, stk_full, stk_empty, err
    );

endinterface

// File: rtl/pc_seq8_ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// DEPTH x 8 return-address LIFO.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (clears sp only)
//   push, din   write din at sp and increment sp (ignored when full)
//   pop         decrement sp (ignored when empty)
//   top         entry at sp-1 (meaningless while empty)
//   sp          occupancy 0..DEPTH
//   full, empty decoded from the registered sp
// Entry storage is not reset; only the occupancy defines what is valid.
// -----------------------------------------------------------------------------
module ret_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  pc_t                          din,
    output pc_t                          top,
    output logic [$clog2(DEPTH+1)-1:0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    pc_t             mem [DEPTH];
    logic [SP_W-1:0] sp_p0;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;
    logic            do_push;
    logic            do_pop;

    assign full    = (sp_p0 == SP_FULL);
    assign empty   = (sp_p0 == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // sp < DEPTH whenever a write happens, so the truncation is lossless.
    assign wr_idx = AW'(sp_p0);
    // Park the read index at 0 while empty to keep it inside the array.
    assign rd_idx = empty ? '0 : AW'(sp_p0 - SP_W'(1));

    assign top = mem[rd_idx];
    assign sp  = sp_p0;

    // occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_p0 <= '0;
        end else if (do_push) begin
            sp_p0 <= sp_p0 + SP_W'(1);
        end else if (do_pop) begin
            sp_p0 <= sp_p0 - SP_W'(1);
        end
    end

    // entry storage
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_seq8.sv
// -----------------------------------------------------------------------------
// pc_seq8
// 8-bit program-counter sequencer feeding the 2:1 operand/address mux
// (pc -> mux input a, target -> mux input b). Supports increment, absolute
// jump, call and return, with return addresses kept in ret_stack.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; wins over every request
//   bus    pc_seq8_if.slave: en/jmp/call/ret/target in,
//          pc/pc_next/sp/stk_full/stk_empty/err out
// Parameters:
//   DEPTH     return-stack entries (2..16)
//   RESET_PC  pc value after reset
//   TRAP_PC   overflow vector, only meaningful with the trap build
// Build option:
//   PC_SEQ8_OVF_TRAP_EN  when defined, a call with the stack full goes to
//                        TRAP_PC instead of target. Default: jump to target,
//                        drop the push.
// -----------------------------------------------------------------------------
module pc_seq8
    import pc_seq_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter pc_t RESET_PC = 8'h00,
    parameter pc_t TRAP_PC  = 8'hF0
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_seq8_if.slave   bus
);

    localparam int SP_W = $clog2(DEPTH + 1);

    cmd_e            req_cmd;
    cmd_e            cmd;
    pc_t             pc_p0;
    pc_t             pc_plus1;
    pc_t             pc_nxt;
    pc_t             ovf_pc;
    pc_t             stk_top;
    logic [SP_W-1:0] sp;
    logic            stk_full;
    logic            stk_empty;
    logic            push;
    logic            pop;
    logic            fault;
    logic            err_p0;

    // pc_next describes the edge where en=1, so it decodes without en;
    // the registered path uses the en-masked command.
    assign req_cmd = decode_cmd(1'b1, bus.ret, bus.call, bus.jmp);
    assign cmd     = decode_cmd(bus.en, bus.ret, bus.call, bus.jmp);

    assign pc_plus1 = pc_inc(pc_p0);

`ifdef PC_SEQ8_OVF_TRAP_EN
    assign ovf_pc = TRAP_PC;
`else
    // Overflowing call still jumps; TRAP_PC has no role in this build.
    logic unused_trap_pc;
    assign ovf_pc         = bus.target;
    assign unused_trap_pc = ^TRAP_PC;
`endif

    always_comb begin
        pc_nxt = pc_plus1;
        case (req_cmd)
            CMD_RET:  pc_nxt = stk_empty ? pc_plus1 : stk_top;
            CMD_CALL: pc_nxt = stk_full ? ovf_pc : bus.target;
            CMD_JMP:  pc_nxt = bus.target;
            CMD_INC:  pc_nxt = pc_plus1;
            default:  pc_nxt = pc_p0;
        endcase
    end

    assign push  = (cmd == CMD_CALL) && !stk_full;
    assign pop   = (cmd == CMD_RET) && !stk_empty;
    assign fault = ((cmd == CMD_CALL) && stk_full) ||
                   ((cmd == CMD_RET) && stk_empty);

    ret_stack #(
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_plus1),
        .top   (stk_top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // pc register and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0  <= RESET_PC;
            err_p0 <= 1'b0;
        end else if (bus.en) begin
            pc_p0 <= pc_nxt;
            if (fault) begin
                err_p0 <= 1'b1;
            end
        end
    end

    assign bus.pc        = pc_p0;
    assign bus.pc_next   = pc_nxt;
    assign bus.sp        = sp;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.err       = err_p0;

endmodule

// File: tb/tb_pc_seq8.sv
// -----------------------------------------------------------------------------
// tb_pc_seq8
// Directed plus random stimulus for pc_seq8 (DEPTH=4). Each driven step
// pushes the reference model's expected state into a scoreboard queue; the
// entry is popped and compared one clock later. Directed constants are
// checked at the key points as well.
// -----------------------------------------------------------------------------
module tb_pc_seq8;

    localparam int        DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;
    localparam logic [7:0] TRAP_PC  = 8'hF0;
`ifdef PC_SEQ8_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] sp;
        logic       err;
        logic       full;
        logic       empty;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    exp_t sb[$];

    logic [7:0] m_pc;
    int         m_sp;
    logic       m_err;
    logic [7:0] m_stk [16];

    pc_seq8_if #(.DEPTH(DEPTH)) bus ();

    pc_seq8 #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .TRAP_PC  (TRAP_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation timeout");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_next_pc(input logic r, input logic c,
                                                 input logic j, input logic [7:0] t);
        logic [7:0] n;
        if (r) begin
            n = (m_sp > 0) ? m_stk[m_sp-1] : m_pc + 8'd1;
        end else if (c) begin
            n = (m_sp < DEPTH) ? t : (TRAP ? TRAP_PC : t);
        end else if (j) begin
            n = t;
        end else begin
            n = m_pc + 8'd1;
        end
        return n;
    endfunction

    task automatic model_adv(input logic e, input logic r, input logic c,
                             input logic j, input logic [7:0] t);
        logic [7:0] n;
        if (!e) return;
        n = model_next_pc(r, c, j, t);
        if (r) begin
            if (m_sp > 0) m_sp--;
            else          m_err = 1'b1;
        end else if (c) begin
            if (m_sp < DEPTH) begin
                m_stk[m_sp] = m_pc + 8'd1;
                m_sp++;
            end else begin
                m_err = 1'b1;
            end
        end
        m_pc = n;
    endtask

    function automatic exp_t model_exp();
        exp_t x;
        x.pc    = m_pc;
        x.sp    = 8'(m_sp);
        x.err   = m_err;
        x.full  = (m_sp == DEPTH);
        x.empty = (m_sp == 0);
        return x;
    endfunction

    task automatic compare_out(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd0, 8'd1);
            return;
        end
        x = sb.pop_front();
        chk({tag, "_pc"},    bus.pc,            x.pc);
        chk({tag, "_sp"},    8'(bus.sp),        x.sp);
        chk({tag, "_err"},   8'(bus.err),       8'(x.err));
        chk({tag, "_full"},  8'(bus.stk_full),  8'(x.full));
        chk({tag, "_empty"}, 8'(bus.stk_empty), 8'(x.empty));
    endtask

    task automatic step(input string tag, input logic e, input logic r,
                        input logic c, input logic j, input logic [7:0] t);
        rst_n      = 1'b1;
        bus.en     = e;
        bus.ret    = r;
        bus.call   = c;
        bus.jmp    = j;
        bus.target = t;
        #1;
        if (e) chk({tag, "_pc_next"}, bus.pc_next, model_next_pc(r, c, j, t));
        model_adv(e, r, c, j, t);
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic do_reset(input string tag, input logic c, input logic [7:0] t);
        rst_n      = 1'b0;
        bus.en     = 1'b1;
        bus.ret    = 1'b0;
        bus.call   = c;
        bus.jmp    = 1'b0;
        bus.target = t;
        m_pc  = RESET_PC;
        m_sp  = 0;
        m_err = 1'b0;
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        compare_out(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.ret    = 1'b0;
        bus.call   = 1'b0;
        bus.jmp    = 1'b0;
        bus.target = 8'h00;
        m_pc       = RESET_PC;
        m_sp       = 0;
        m_err      = 1'b0;
        for (int i = 0; i < 16; i++) m_stk[i] = 8'h00;

        // reset with a call request pending: reset wins
        do_reset("rst0", 1'b1, 8'h33);
        chk("rst0_pc_const", bus.pc, 8'h00);
        chk("rst0_empty_const", 8'(bus.stk_empty), 8'd1);

        // three idle cycles
        step("idle1", 1, 0, 0, 0, 8'h00);
        step("idle2", 1, 0, 0, 0, 8'h00);
        step("idle3", 1, 0, 0, 0, 8'h00);
        chk("idle_pc_const", bus.pc, 8'h03);

        // call / ret pair
        step("jmp05", 1, 0, 0, 1, 8'h05);
        step("call40", 1, 0, 1, 0, 8'h40);
        chk("call40_pc_const", bus.pc, 8'h40);
        chk("call40_sp_const", 8'(bus.sp), 8'd1);
        step("ret06", 1, 1, 0, 0, 8'h00);
        chk("ret06_pc_const", bus.pc, 8'h06);
        chk("ret06_empty_const", 8'(bus.stk_empty), 8'd1);

        // nested calls up to overflow
        step("jmp10", 1, 0, 0, 1, 8'h10);
        for (int i = 0; i < 5; i++) step("nest", 1, 0, 1, 0, 8'h20 + 8'(i));
        chk("ovf_pc_const", bus.pc, TRAP ? 8'hF0 : 8'h24);
        chk("ovf_sp_const", 8'(bus.sp), 8'd4);
        chk("ovf_full_const", 8'(bus.stk_full), 8'd1);
        chk("ovf_err_const", 8'(bus.err), 8'd1);
        step("unwind1", 1, 1, 0, 0, 8'h00);
        chk("unwind1_pc_const", bus.pc, 8'h23);
        step("unwind2", 1, 1, 0, 0, 8'h00);
        step("unwind3", 1, 1, 0, 0, 8'h00);
        chk("unwind3_pc_const", bus.pc, 8'h21);
        step("unwind4", 1, 1, 0, 0, 8'h00);
        chk("unwind4_pc_const", bus.pc, 8'h11);
        chk("unwind4_sp_const", 8'(bus.sp), 8'd0);

        // underflow and sticky err
        do_reset("rst1", 1'b0, 8'h00);
        step("jmp7f", 1, 0, 0, 1, 8'h7F);
        step("uflow", 1, 1, 0, 0, 8'h00);
        chk("uflow_pc_const", bus.pc, 8'h80);
        chk("uflow_err_const", 8'(bus.err), 8'd1);
        step("sticky1", 1, 0, 0, 0, 8'h00);
        step("sticky2", 1, 0, 0, 1, 8'h12);
        step("sticky3", 1, 0, 1, 0, 8'h20);
        step("sticky4", 1, 1, 0, 0, 8'h00);
        chk("sticky_err_const", 8'(bus.err), 8'd1);
        do_reset("rst2", 1'b0, 8'h00);
        chk("rst2_err_const", 8'(bus.err), 8'd0);

        // modulo-256 wrap
        step("jmpff", 1, 0, 0, 1, 8'hFF);
        step("wrap", 1, 0, 0, 0, 8'h00);
        chk("wrap_pc_const", bus.pc, 8'h00);
        step("jmpff2", 1, 0, 0, 1, 8'hFF);
        step("callff", 1, 0, 1, 0, 8'h30);
        step("retff", 1, 1, 0, 0, 8'h00);
        chk("retff_pc_const", bus.pc, 8'h00);

        // simultaneous requests
        step("jmp54", 1, 0, 0, 1, 8'h54);
        step("call60", 1, 0, 1, 0, 8'h60);
        step("all_en0", 0, 1, 1, 1, 8'h77);
        chk("all_en0_pc_const", bus.pc, 8'h60);
        chk("all_en0_sp_const", 8'(bus.sp), 8'd1);
        step("all_en1", 1, 1, 1, 1, 8'h77);
        chk("all_en1_pc_const", bus.pc, 8'h55);
        chk("all_en1_sp_const", 8'(bus.sp), 8'd0);

        // reset mid-sequence discards the stack
        step("mid_call1", 1, 0, 1, 0, 8'h40);
        step("mid_call2", 1, 0, 1, 0, 8'h50);
        do_reset("rst3", 1'b1, 8'h99);
        chk("rst3_sp_const", 8'(bus.sp), 8'd0);
        step("mid_ret", 1, 1, 0, 0, 8'h00);
        chk("mid_ret_pc_const", bus.pc, 8'h01);
        chk("mid_ret_err_const", 8'(bus.err), 8'd1);

        // random mix against the model
        do_reset("rst4", 1'b0, 8'h00);
        for (int i = 0; i < 120; i++) begin
            step("rnd",
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 255)));
        end

        chk("sb_left", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
